// File: rtl/sap_core.sv
// SAP-style accumulator CPU core: internal RAM, carry/zero flags, conditional jumps, OUT port, program-load port.
// Optional macro SAP_STEP_EN adds a 'step' input for single-instruction execution from IDLE.
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              clk_en,
  input  logic              run,
`ifdef SAP_STEP_EN
  input  logic              step,
`endif
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_c,
  output logic              flag_z
);

  localparam int unsigned OPR_W = DATA_W - 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  if (DATA_W < 8 || ADDR_W > DATA_W - 4) begin : g_param_err
    $error("sap_core: need DATA_W >= 8 and ADDR_W <= DATA_W-4");
  end

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_HALT} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   a, a_n, b, b_n, ir, ir_n, out_n;
  logic [ADDR_W-1:0]   mar, mar_n, pc_n;
  logic                c_n, z_n, out_valid_n, halted_n;
  logic [DATA_W:0]     sum;
  logic                start;
  logic [3:0]          op;
  logic [OPR_W-1:0]    operand;
  logic [ADDR_W-1:0]   opr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  assign op      = ir[DATA_W-1 -: 4];
  assign operand = ir[OPR_W-1:0];
  assign opr     = ir[ADDR_W-1:0];

`ifdef SAP_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // Next-state and datapath decode
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    a_n         = a;
    b_n         = b;
    mar_n       = mar;
    ir_n        = ir;
    out_n       = out_data;
    c_n         = flag_c;
    z_n         = flag_z;
    out_valid_n = 1'b0;
    halted_n    = halted;
    sum         = '0;
    mem_we      = 1'b0;
    mem_addr    = prog_addr;
    mem_wdata   = prog_data;

    if (prog_we && (state == S_IDLE || state == S_HALT)) begin
      mem_we = 1'b1;
    end

    if (clk_en) begin
      case (state)
        S_IDLE: if (start) state_n = S_T0;
        S_T0: begin
          mar_n   = pc;
          state_n = S_T1;
        end
        S_T1: begin
          ir_n    = mem[mar];
          pc_n    = pc + ADDR_W'(1);
          state_n = S_T2;
        end
        S_T2: begin
          state_n = run ? S_T0 : S_IDLE;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_n   = opr;
              state_n = S_T3;
            end
            OP_LDI: a_n = DATA_W'(operand);
            OP_JMP: pc_n = opr;
            OP_JC:  if (flag_c) pc_n = opr;
            OP_JZ:  if (flag_z) pc_n = opr;
            OP_OUT: begin
              out_n       = a;
              out_valid_n = 1'b1;
            end
            OP_HLT: begin
              state_n  = S_HALT;
              halted_n = 1'b1;
            end
            default: ;
          endcase
        end
        S_T3: begin
          state_n = run ? S_T0 : S_IDLE;
          case (op)
            OP_LDA: a_n = mem[mar];
            OP_STA: begin
              mem_we    = 1'b1;
              mem_addr  = mar;
              mem_wdata = a;
            end
            OP_ADD: begin
              b_n = mem[mar];
              sum = {1'b0, a} + {1'b0, b_n};
              {c_n, a_n} = sum;
              z_n = (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              // Two's-complement subtract: carry out = no borrow
              b_n = mem[mar];
              sum = {1'b0, a} + {1'b0, ~b_n} + (DATA_W+1)'(1);
              {c_n, a_n} = sum;
              z_n = (sum[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state     <= S_IDLE;
      pc        <= '0;
      a         <= '0;
      b         <= '0;
      mar       <= '0;
      ir        <= '0;
      out_data  <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      a         <= a_n;
      b         <= b_n;
      mar       <= mar_n;
      ir        <= ir_n;
      out_data  <= out_n;
      flag_c    <= c_n;
      flag_z    <= z_n;
      out_valid <= out_valid_n;
      halted    <= halted_n;
    end
  end

  // Program/data RAM; contents survive reset, but no write lands during reset
  always_ff @(posedge clk) begin
    if (rst_btn && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: instruction-level reference model plus directed and random programs.
module tb_sap_core;

  logic       clk = 1'b0;
  logic       rst_btn, clk_en, run, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data;
  logic       out_valid, halted, flag_c, flag_z;
  logic [3:0] pc;
`ifdef SAP_STEP_EN
  logic       step;
`endif

  int checks = 0;
  int passed = 0;

  logic [7:0] prog [16];

  // Instruction-level reference model
  logic [7:0] m_ram [16];
  logic [7:0] m_a, m_out, m_ir;
  logic [3:0] m_pc;
  logic       m_c, m_z, m_idle, m_halt, m_ov;
  int         m_left;
  bit         model_on = 1'b0;

  sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_btn(rst_btn), .clk_en(clk_en), .run(run),
`ifdef SAP_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .out_data(out_data), .out_valid(out_valid), .halted(halted), .pc(pc),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_tick();
    logic [3:0] op, opr;
    logic [8:0] s;
    logic       go;
    if (m_halt) return;
    if (m_idle) begin
      go = run;
`ifdef SAP_STEP_EN
      go = run | step;
`endif
      if (go) begin
        m_idle = 1'b0;
        m_left = 0;
      end
      return;
    end
    if (m_left == 0) begin
      m_ir   = m_ram[m_pc];
      op     = m_ir[7:4];
      m_left = (op >= 4'd1 && op <= 4'd4) ? 4 : 3;
    end
    m_left--;
    if (m_left != 0) return;
    op   = m_ir[7:4];
    opr  = m_ir[3:0];
    m_pc = m_pc + 4'd1;
    case (op)
      4'h1: m_a = m_ram[opr];
      4'h2: begin
        s   = {1'b0, m_a} + {1'b0, m_ram[opr]};
        m_c = s[8];
        m_a = s[7:0];
        m_z = (m_a == 8'd0);
      end
      4'h3: begin
        m_c = (m_a >= m_ram[opr]);
        m_a = m_a - m_ram[opr];
        m_z = (m_a == 8'd0);
      end
      4'h4: m_ram[opr] = m_a;
      4'h5: m_a = {4'd0, opr};
      4'h6: m_pc = opr;
      4'h7: if (m_c) m_pc = opr;
      4'h8: if (m_z) m_pc = opr;
      4'hE: begin
        m_out = m_a;
        m_ov  = 1'b1;
      end
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    if (!m_halt && !run) m_idle = 1'b1;
  endtask

  // Model advance on each edge, then compare once outputs have settled
  always @(posedge clk) begin
    m_ov = 1'b0;
    if (!rst_btn) begin
      m_a = 8'd0; m_out = 8'd0; m_pc = 4'd0; m_c = 1'b0; m_z = 1'b0;
      m_idle = 1'b1; m_halt = 1'b0; m_left = 0;
    end else begin
      if (prog_we && (m_idle || m_halt)) m_ram[prog_addr] = prog_data;
      if (clk_en) model_tick();
    end
    #1;
    if (model_on) begin
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("halted", int'(halted), int'(m_halt));
      chk("out_data", int'(out_data), int'(m_out));
      chk("flag_c", int'(flag_c), int'(m_c));
      chk("flag_z", int'(flag_z), int'(m_z));
      if (m_left == 0) chk("pc", int'(pc), int'(m_pc));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_btn = 1'b0; run = 1'b0; prog_we = 1'b0; clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_btn = 1'b1;
  endtask

  task automatic write_one(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_to_halt(output int n, output int pulses);
    n = 0; pulses = 0; run = 1'b1;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid) pulses++;
    end
    if (!halted) chk("halt_timeout", 0, 1);
  endtask

  initial begin
    int n, pulses;
    rst_btn = 1'b0; clk_en = 1'b1; run = 1'b0; prog_we = 1'b0;
    prog_addr = 4'd0; prog_data = 8'd0;
`ifdef SAP_STEP_EN
    step = 1'b0;
`endif
    do_reset();
    model_on = 1'b1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_out", int'(out_data), 0);
    chk("rst_halted", int'(halted), 0);

    // LDI 5; ADD E; OUT; HLT with ram[E]=3
    prog = '{default: 8'h00};
    prog[0] = 8'h55; prog[1] = 8'h2E; prog[2] = 8'hE0; prog[3] = 8'hF0; prog[14] = 8'h03;
    load_prog();
    run_to_halt(n, pulses);
    chk("t1_ticks", n, 14);
    chk("t1_pulses", pulses, 1);
    chk("t1_out", int'(out_data), 8'h08);
    chk("t1_c", int'(flag_c), 0);
    chk("t1_z", int'(flag_z), 0);
    chk("t1_pc", int'(pc), 4);

    // SUB to zero then JZ 9
    do_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h57; prog[1] = 8'h3E; prog[2] = 8'h89; prog[3] = 8'h51; prog[4] = 8'hE0;
    prog[5] = 8'hF0; prog[9] = 8'h5B; prog[10] = 8'hE0; prog[11] = 8'hF0; prog[14] = 8'h07;
    load_prog();
    run_to_halt(n, pulses);
    chk("t2_out", int'(out_data), 8'h0B);
    chk("t2_c", int'(flag_c), 1);
    chk("t2_z", int'(flag_z), 1);
    chk("t2_pc", int'(pc), 12);

    // 0xFF + 1 wraps with carry, JC taken
    do_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h75; prog[3] = 8'hF0;
    prog[5] = 8'hE0; prog[6] = 8'hF0; prog[14] = 8'hFF; prog[15] = 8'h01;
    load_prog();
    run_to_halt(n, pulses);
    chk("t3a_pulses", pulses, 1);
    chk("t3a_out", int'(out_data), 8'h00);
    chk("t3a_c", int'(flag_c), 1);
    chk("t3a_z", int'(flag_z), 1);
    chk("t3a_pc", int'(pc), 7);

    // 3 - 5 borrows
    do_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h53; prog[1] = 8'h3F; prog[2] = 8'hE0; prog[3] = 8'hF0; prog[15] = 8'h05;
    load_prog();
    run_to_halt(n, pulses);
    chk("t3b_out", int'(out_data), 8'hFE);
    chk("t3b_c", int'(flag_c), 0);
    chk("t3b_z", int'(flag_z), 0);

    // All-NOP sweep with pc wrap, then clk_en hold
    do_reset();
    prog = '{default: 8'h00};
    load_prog();
    run = 1'b1;
    repeat (46) @(negedge clk);
    chk("t4_pc15", int'(pc), 15);
    repeat (3) @(negedge clk);
    chk("t4_wrap", int'(pc), 0);
    clk_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_hold_pc", int'(pc), 0);
    chk("t4_hold_halted", int'(halted), 0);
    for (int i = 0; i < 60; i++) begin
      clk_en = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    clk_en = 1'b1; run = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during STA T3; prog_we while running ignored
    do_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h59; prog[1] = 8'h45; prog[2] = 8'hF0; prog[5] = 8'h33;
    load_prog();
    run = 1'b1;
    repeat (2) @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'h77;
    @(negedge clk);
    prog_we = 1'b0;
    repeat (4) @(negedge clk);
    rst_btn = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("t5_rst_pc", int'(pc), 0);
    chk("t5_rst_out", int'(out_data), 0);
    chk("t5_rst_c", int'(flag_c), 0);
    chk("t5_rst_ov", int'(out_valid), 0);
    rst_btn = 1'b1;
    write_one(4'd0, 8'h15);
    write_one(4'd1, 8'hE0);
    write_one(4'd2, 8'hF0);
    run_to_halt(n, pulses);
    chk("t5_ram5", int'(out_data), 8'h33);

`ifdef SAP_STEP_EN
    do_reset();
    prog = '{default: 8'h00};
    load_prog();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_step_pc", int'(pc), 1);
`endif

    // Random programs under random clk_en/run/prog_we/reset
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      load_prog();
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        clk_en    = ($urandom_range(0, 3) != 0);
        run       = ($urandom_range(0, 15) != 0);
        prog_we   = ($urandom_range(0, 7) == 0);
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
        rst_btn   = ($urandom_range(0, 199) != 0);
      end
      @(negedge clk);
      rst_btn = 1'b1; prog_we = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
